// File: rtl/sa_result_drain_if.sv
// Handshake and data bundle between the systolic-array controller side and the
// result drain: start/base in, skewed column data in, SRAM row writes and status out.
interface sa_result_drain_if #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int AW = 8
);
   logic              start;
   logic [AW-1:0]     base_addr;
   logic [N*DW-1:0]   col_data;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [N*DW-1:0]   mem_wdata;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, base_addr, col_data,
      input  mem_we, mem_addr, mem_wdata, busy, done, err
   );

   modport slave (
      input  start, base_addr, col_data,
      output mem_we, mem_addr, mem_wdata, busy, done, err
   );
endinterface

// File: rtl/sa_result_drain.sv
// Deskews the diagonal result wavefront from the array's bottom edge into
// N aligned rows and writes them to consecutive SRAM addresses.
module sa_result_drain #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int AW = 8
) (
   input  logic            clk,
   input  logic            rst,
   sa_result_drain_if.slave bus
);
   localparam int KW = $clog2(2 * N);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   localparam logic [KW-1:0] K_FIRST_WR = KW'(N - 1);
   localparam logic [KW-1:0] K_LAST_WR  = KW'(2 * N - 2);
   localparam logic [KW-1:0] K_END      = KW'(2 * N - 1);

   logic [0:0]      state;
   logic [KW-1:0]   k;
   logic [AW-1:0]   addr_q;
   logic [N*DW-1:0] row;
   logic            wr_edge;

   logic            mem_we_q;
   logic [AW-1:0]   mem_addr_q;
   logic [N*DW-1:0] mem_wdata_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;

   // Column j is seen j edges after column 0, so it waits N-1-j edges to line up.
   for (genvar j = 0; j < N; j++) begin : g_col
      localparam int L = N - 1 - j;
      if (L == 0) begin : g_direct
         assign row[j*DW +: DW] = bus.col_data[j*DW +: DW];
      end else begin : g_dly
         logic [DW-1:0] sr [L];
         // NOTE: the deskew chain is a handful of flops, not a RAM, so it is
         // reset like any other state and never exposes stale data after rst.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int r = 0; r < L; r++) sr[r] <= '0;
            end else begin
               sr[0] <= bus.col_data[j*DW +: DW];
               for (int r = 1; r < L; r++) sr[r] <= sr[r-1];
            end
         end
         assign row[j*DW +: DW] = sr[L-1];
      end
   end

   assign wr_edge = (state == DRAIN) && (k >= K_FIRST_WR) && (k <= K_LAST_WR);

   // NOTE: all state here updates with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         k           <= '0;
         addr_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_we_q <= wr_edge;
         done_q   <= 1'b0;

         // Address register doubles as base + row index, wrapping modulo 2^AW.
         if (wr_edge) begin
            mem_addr_q  <= addr_q;
            mem_wdata_q <= row;
            addr_q      <= addr_q + AW'(1);
         end

         if (state == IDLE) begin
            if (bus.start) begin
               state  <= DRAIN;
               k      <= KW'(1);
               addr_q <= bus.base_addr;
               busy_q <= 1'b1;
               err_q  <= 1'b0;
            end
         end else begin
            // A start during the drain, including its final edge, is rejected.
            if (bus.start) err_q <= 1'b1;
            if (k == K_END) begin
               state  <= IDLE;
               k      <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               k <= k + KW'(1);
            end
         end
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_sa_result_drain.sv
// Self-checking bench for sa_result_drain: scenario table, hand-written corner
// sequences and a random run, all checked against a cycle-level tile model.
module tb_sa_result_drain;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int RW = N * DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sa_result_drain_if #(.N(N), .DW(DW), .AW(AW)) bus ();
   sa_result_drain #(.N(N), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one accepted tile at a time, described by its start edge and matrix.
   logic [DW-1:0] mat      [N][N];
   logic [DW-1:0] next_mat [N][N];
   bit            tv = 0;
   int            s  = -100;
   logic [AW-1:0] mbase;
   bit            m_err = 0;
   logic [AW-1:0] e_addr  = '0;
   logic [RW-1:0] e_wdata = '0;
   int            cyc = 0;
   bit            fill_ff = 0;

   int            t0 = 0;
   bit            o_we   [64];
   bit            o_busy [64];
   bit            o_done [64];
   logic [AW-1:0] o_addr [64];
   logic [RW-1:0] o_wdata[64];

   function automatic logic [RW-1:0] row_of(input int i);
      logic [RW-1:0] r;
      for (int j = 0; j < N; j++) r[j*DW +: DW] = mat[i][j];
      return r;
   endfunction

   task automatic fill_pattern(input bit rnd);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            next_mat[i][j] = rnd ? DW'($urandom_range(0, 16'hFFFE))
                                 : {i[3:0], j[3:0], i[3:0], j[3:0]};
   endtask

   // Called at a falling edge: drives the next rising edge, then checks the cycle after it.
   task automatic step(input bit st, input logic [AW-1:0] b, input bit r);
      logic [RW-1:0] cd;
      int c;
      bit e_we, e_busy, e_done;
      rst = r;
      if (r) begin
         tv = 0; m_err = 0; e_addr = '0; e_wdata = '0;
      end else if (st) begin
         if (!tv || cyc >= s + 2 * N) begin
            tv = 1; s = cyc; mbase = b; m_err = 0; mat = next_mat;
         end else begin
            m_err = 1;
         end
      end
      bus.start     = st && !r;
      bus.base_addr = b;
      for (int j = 0; j < N; j++) begin
         int i;
         i = cyc - s - j;
         if (tv && i >= 0 && i < N) cd[j*DW +: DW] = mat[i][j];
         else cd[j*DW +: DW] = fill_ff ? 16'hFFFF : DW'($urandom);
      end
      bus.col_data = cd;

      @(posedge clk);
      @(negedge clk);
      c      = cyc + 1;
      e_we   = tv && c >= s + N && c <= s + 2 * N - 1;
      e_busy = tv && c >= s + 1 && c <= s + 2 * N - 1;
      e_done = tv && c == s + 2 * N;
      if (e_we) begin
         e_addr  = mbase + AW'(c - s - N);
         e_wdata = row_of(c - s - N);
      end
      check("mem_we",    RW'(bus.mem_we), RW'(e_we));
      check("busy",      RW'(bus.busy),   RW'(e_busy));
      check("done",      RW'(bus.done),   RW'(e_done));
      check("err",       RW'(bus.err),    RW'(m_err));
      check("mem_addr",  RW'(bus.mem_addr), RW'(e_addr));
      check("mem_wdata", bus.mem_wdata,   e_wdata);
      if (fill_ff && bus.mem_we)
         for (int j = 0; j < N; j++)
            check($sformatf("no_ffff_col%0d", j),
                  RW'(bus.mem_wdata[j*DW +: DW] == 16'hFFFF), '0);
      if (c - t0 >= 0 && c - t0 < 64) begin
         o_we[c-t0]    = bus.mem_we;
         o_busy[c-t0]  = bus.busy;
         o_done[c-t0]  = bus.done;
         o_addr[c-t0]  = bus.mem_addr;
         o_wdata[c-t0] = bus.mem_wdata;
      end
      cyc = c;
   endtask

   typedef struct {
      string         name;
      logic [AW-1:0] base;
      int            t2;          // relative cycle of a second start, -1 for none
      bit            pat_rand;
      bit            ff;
      int            exp_writes;
      int            exp_dones;
      bit            exp_err;
      logic [AW-1:0] exp_first;
      logic [AW-1:0] exp_last;
   } vec_t;

   localparam int LEN = 20;

   task automatic run_scenario(input vec_t v);
      int writes, dones;
      bit seen;
      logic [AW-1:0] first_a, last_a;
      fill_ff = v.ff;
      step(0, '0, 0);
      step(0, '0, 0);
      fill_pattern(v.pat_rand);
      t0 = cyc;
      for (int t = 0; t < 64; t++) begin
         o_we[t] = 0; o_busy[t] = 0; o_done[t] = 0; o_addr[t] = '0; o_wdata[t] = '0;
      end
      for (int t = 0; t < LEN; t++)
         step((t == 0) || (t == v.t2), (t == 0) ? v.base : v.base + AW'(N), 0);
      writes = 0; dones = 0; seen = 0; first_a = '0; last_a = '0;
      for (int t = 1; t <= LEN; t++) begin
         if (o_we[t]) begin
            writes++;
            if (!seen) first_a = o_addr[t];
            seen = 1;
            last_a = o_addr[t];
         end
         if (o_done[t]) dones++;
      end
      check({v.name, "_writes"},     RW'(writes),  RW'(v.exp_writes));
      check({v.name, "_dones"},      RW'(dones),   RW'(v.exp_dones));
      check({v.name, "_err_end"},    RW'(bus.err), RW'(v.exp_err));
      check({v.name, "_first_addr"}, RW'(first_a), RW'(v.exp_first));
      check({v.name, "_last_addr"},  RW'(last_a),  RW'(v.exp_last));
      fill_ff = 0;
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{"basic",     8'h10, -1, 0, 0, 4, 1, 0, 8'h10, 8'h13};
      vecs[1] = '{"garbage",   8'h10, -1, 0, 1, 4, 1, 0, 8'h10, 8'h13};
      vecs[2] = '{"busy_st",   8'h10,  3, 0, 0, 4, 1, 1, 8'h10, 8'h13};
      vecs[3] = '{"wrap",      8'hFE, -1, 0, 0, 4, 1, 0, 8'hFE, 8'h01};
      vecs[4] = '{"done_edge", 8'h30,  7, 1, 0, 4, 1, 1, 8'h30, 8'h33};
      vecs[5] = '{"b2b",       8'h20,  9, 1, 1, 8, 2, 0, 8'h20, 8'h27};
      vecs[6] = '{"b2b_tight", 8'h40,  8, 1, 0, 8, 2, 0, 8'h40, 8'h47};

      bus.start = 0; bus.base_addr = '0; bus.col_data = '0;
      #1;
      check("rst_mem_we",    RW'(bus.mem_we), '0);
      check("rst_mem_addr",  RW'(bus.mem_addr), '0);
      check("rst_mem_wdata", bus.mem_wdata, '0);
      check("rst_busy",      RW'(bus.busy), '0);
      check("rst_done",      RW'(bus.done), '0);
      check("rst_err",       RW'(bus.err), '0);
      @(negedge clk);

      // Basic tile with exact cycle placement of busy, writes and done.
      run_scenario(vecs[0]);
      for (int c = 1; c <= 12; c++) begin
         check($sformatf("basic_busy_c%0d", c), RW'(o_busy[c]), RW'(c >= 1 && c <= 7));
         check($sformatf("basic_we_c%0d", c),   RW'(o_we[c]),   RW'(c >= 4 && c <= 7));
         check($sformatf("basic_done_c%0d", c), RW'(o_done[c]), RW'(c == 8));
      end
      for (int c = 4; c <= 7; c++)
         check($sformatf("basic_addr_c%0d", c), RW'(o_addr[c]), RW'(8'h10 + AW'(c - 4)));
      check("basic_row2", o_wdata[6], 64'h2323_2222_2121_2020);

      for (int i = 0; i < 7; i++) run_scenario(vecs[i]);

      // Reset in the middle of a drain.
      step(0, '0, 0);
      fill_pattern(0);
      step(1, 8'h10, 0);
      for (int t = 1; t <= 4; t++) step(0, '0, 0);
      check("pre_rst_we", RW'(bus.mem_we), RW'(1'b1));
      rst = 1'b1;
      #1;
      check("async_rst_we",    RW'(bus.mem_we), '0);
      check("async_rst_busy",  RW'(bus.busy), '0);
      check("async_rst_addr",  RW'(bus.mem_addr), '0);
      check("async_rst_wdata", bus.mem_wdata, '0);
      @(negedge clk);
      step(0, '0, 1);
      step(0, '0, 1);
      for (int t = 0; t < 12; t++) step(0, '0, 0);
      run_scenario(vecs[0]);

      // Random run: sporadic starts, random bases and data, rare resets.
      for (int t = 0; t < 600; t++) begin
         bit st;
         st = ($urandom_range(0, 5) == 0);
         if (st) fill_pattern(1);
         step(st, AW'($urandom), ($urandom_range(0, 149) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
